// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer, N_OUT MAC lanes fed one weight row per cycle.
// Build option: define DENSE_LAYER_ROUND_EN for round-half-up rescaling (default build floors).
module dense_layer_seq #(
    parameter int N_IN  = 128,
    parameter int N_OUT = 3,
    parameter int DW    = 9,
    parameter int FRAC  = 4,
    parameter int AW    = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [N_IN*DW-1:0]    in_vec,
    input  logic [N_OUT*DW-1:0]   bias_vec,
    output logic                  wt_rd_en,
    output logic [AW-1:0]         wt_addr,
    input  logic [N_OUT*DW-1:0]   wt_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT*DW-1:0]   out_vec
);

    localparam int ACC_W = 2*DW + AW + 1;
    localparam int PW    = 2*DW;
    localparam int SW    = ACC_W + 1;

    localparam logic [AW-1:0]        LAST_ADDR = AW'(N_IN - 32'sd1);
    localparam logic signed [DW-1:0] D_MAX     = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN     = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [SW-1:0] S_MAX     = SW'(D_MAX);
    localparam logic signed [SW-1:0] S_MIN     = SW'(D_MIN);
`ifdef DENSE_LAYER_ROUND_EN
    localparam logic signed [SW-1:0] HALF_LSB  = {{(SW-1){1'b0}}, 1'b1} <<< (FRAC - 32'sd1);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    rd_en_q, rd_en_d;
    logic                    done_q, done_d;
    logic                    vld_q, vld_d;
    logic [AW-1:0]           row_q, row_d;
    logic                    relu_q, relu_d;
    logic signed [DW-1:0]    in_q  [N_IN];
    logic signed [DW-1:0]    in_d  [N_IN];
    logic signed [ACC_W-1:0] acc_q [N_OUT];
    logic signed [ACC_W-1:0] acc_d [N_OUT];
    logic [N_OUT*DW-1:0]     out_q, out_d;

    logic                    accept_s;
    logic signed [DW-1:0]    in_sel_s;
    logic signed [DW-1:0]    wt_s   [N_OUT];
    logic signed [PW-1:0]    prod_s [N_OUT];
    logic signed [DW-1:0]    bias_s [N_OUT];
    logic signed [SW-1:0]    sum_s  [N_OUT];
    logic signed [SW-1:0]    shr_s  [N_OUT];
    logic signed [DW-1:0]    sat_s  [N_OUT];
    logic signed [DW-1:0]    res_s  [N_OUT];

    assign accept_s = start && (state_q == IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, registered so busy/rd_en line up with the state they describe.
    always_comb begin
        busy_d  = (state_d != IDLE);
        rd_en_d = (state_d == RUN);
        done_d  = (state_q == FINISH);
    end

    // Row counter doubles as the weight address; it returns to zero after the last row.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_s) begin
            cnt_d = {AW{1'b0}};
        end else if (state_q == RUN) begin
            if (cnt_q == LAST_ADDR) begin
                cnt_d = {AW{1'b0}};
            end else begin
                cnt_d = cnt_q + AW'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        // Read data arrives one cycle after the address, so track it one cycle behind.
        vld_d = rd_en_q;
        row_d = cnt_q;
    end

    // Operand capture: inputs and ReLU mode are frozen for the whole computation.
    always_comb begin
        relu_d = relu_q;
        for (int j = 0; j < N_IN; j++) begin
            in_d[j] = in_q[j];
        end
        if (accept_s) begin
            relu_d = relu_en;
            for (int j = 0; j < N_IN; j++) begin
                in_d[j] = in_vec[j*DW +: DW];
            end
        end else begin
            relu_d = relu_q;
        end
    end

    // MAC lanes: one row of weights times the matching input element per cycle.
    always_comb begin
        in_sel_s = in_q[row_q];
        for (int i = 0; i < N_OUT; i++) begin
            wt_s[i]   = wt_rdata[i*DW +: DW];
            prod_s[i] = PW'(in_sel_s) * PW'(wt_s[i]);
            if (accept_s) begin
                acc_d[i] = {ACC_W{1'b0}};
            end else if (vld_q) begin
                acc_d[i] = acc_q[i] + ACC_W'(prod_s[i]);
            end else begin
                acc_d[i] = acc_q[i];
            end
        end
    end

    // Bias add, rescale, saturate and optional ReLU; result captured only in FINISH.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < N_OUT; i++) begin
            bias_s[i] = bias_vec[i*DW +: DW];
            sum_s[i]  = SW'(acc_q[i]) + (SW'(bias_s[i]) <<< FRAC);
`ifdef DENSE_LAYER_ROUND_EN
            sum_s[i]  = sum_s[i] + HALF_LSB;
`endif
            shr_s[i]  = sum_s[i] >>> FRAC;
            if (shr_s[i] > S_MAX) begin
                sat_s[i] = D_MAX;
            end else if (shr_s[i] < S_MIN) begin
                sat_s[i] = D_MIN;
            end else begin
                sat_s[i] = shr_s[i][DW-1:0];
            end
            if (relu_q && sat_s[i][DW-1]) begin
                res_s[i] = {DW{1'b0}};
            end else begin
                res_s[i] = sat_s[i];
            end
        end
        if (state_q == FINISH) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_d[i*DW +: DW] = res_s[i];
            end
        end else begin
            out_d = out_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= {AW{1'b0}};
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            row_q   <= {AW{1'b0}};
            relu_q  <= 1'b0;
            out_q   <= {(N_OUT*DW){1'b0}};
            for (int j = 0; j < N_IN; j++) begin
                in_q[j] <= {DW{1'b0}};
            end
            for (int i = 0; i < N_OUT; i++) begin
                acc_q[i] <= {ACC_W{1'b0}};
            end
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            row_q   <= row_d;
            relu_q  <= relu_d;
            out_q   <= out_d;
            for (int j = 0; j < N_IN; j++) begin
                in_q[j] <= in_d[j];
            end
            for (int i = 0; i < N_OUT; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign wt_rd_en = rd_en_q;
    assign wt_addr  = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out_vec  = out_q;

endmodule
